// File: rtl/br_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: branch condition encodings and
// the per-stage prediction metadata record.
package br_pkg;

    // GHR width carried in br_meta_t; the top's HISTORY_WIDTH defaults to it.
    localparam int unsigned BR_HISTORY_WIDTH = 8;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_funct3_e;

    typedef struct packed {
        logic                        valid;
        logic [31:0]                 pc;
        logic                        btb_hit;
        logic                        prediction;
        logic [31:0]                 pred_target;
        logic [BR_HISTORY_WIDTH-1:0] ghr;
    } br_meta_t;

endpackage

// File: rtl/br_resolve_unit_if.sv
// Fetch metadata, EX operands and the EX/MEM commit record of the resolve unit.
interface br_resolve_unit_if #(
    parameter int unsigned INDEX_WIDTH   = 6,
    parameter int unsigned HISTORY_WIDTH = br_pkg::BR_HISTORY_WIDTH
);
    localparam int unsigned TAG_W = 32 - INDEX_WIDTH - 2;

    logic                     IF_valid_i;
    logic [31:0]              IF_pc_i;
    logic                     IF_btb_hit_i;
    logic                     IF_prediction_i;
    logic [31:0]              IF_btb_target_i;
    logic [HISTORY_WIDTH-1:0] IF_ghr_data_i;

    logic                     EX_is_branch_i;
    logic                     EX_is_jal_i;
    logic                     EX_is_jalr_i;
    logic [2:0]               EX_funct3_i;
    logic [31:0]              EX_rs1_i;
    logic [31:0]              EX_rs2_i;
    logic [31:0]              EX_imm_i;

    logic                     EXMEM_btb_hit_o;
    logic                     EXMEM_br_decision_o;
    logic                     EXMEM_is_jmp_o;
    logic                     EXMEM_prediction_o;
    logic [HISTORY_WIDTH-1:0] EXMEM_ghr_data_o;
    logic [INDEX_WIDTH-1:0]   EXMEM_btb_wr_index_o;
    logic [TAG_W-1:0]         EXMEM_btb_wr_tag_o;
    logic [31:0]              EXMEM_btb_wr_target_o;
    logic [HISTORY_WIDTH-1:0] EXMEM_pht_wr_index_o;
    logic [31:0]              EXMEM_pcplus4_o;

    modport master (
        output IF_valid_i, IF_pc_i, IF_btb_hit_i, IF_prediction_i,
               IF_btb_target_i, IF_ghr_data_i,
               EX_is_branch_i, EX_is_jal_i, EX_is_jalr_i, EX_funct3_i,
               EX_rs1_i, EX_rs2_i, EX_imm_i,
        input  EXMEM_btb_hit_o, EXMEM_br_decision_o, EXMEM_is_jmp_o,
               EXMEM_prediction_o, EXMEM_ghr_data_o, EXMEM_btb_wr_index_o,
               EXMEM_btb_wr_tag_o, EXMEM_btb_wr_target_o,
               EXMEM_pht_wr_index_o, EXMEM_pcplus4_o
    );

    modport slave (
        input  IF_valid_i, IF_pc_i, IF_btb_hit_i, IF_prediction_i,
               IF_btb_target_i, IF_ghr_data_i,
               EX_is_branch_i, EX_is_jal_i, EX_is_jalr_i, EX_funct3_i,
               EX_rs1_i, EX_rs2_i, EX_imm_i,
        output EXMEM_btb_hit_o, EXMEM_br_decision_o, EXMEM_is_jmp_o,
               EXMEM_prediction_o, EXMEM_ghr_data_o, EXMEM_btb_wr_index_o,
               EXMEM_btb_wr_tag_o, EXMEM_btb_wr_target_o,
               EXMEM_pht_wr_index_o, EXMEM_pcplus4_o
    );

endinterface

// File: rtl/br_resolve_unit_cond.sv
// Combinational branch condition evaluation; reserved funct3 codes never take.
module br_cond_unit
    import br_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        cond_o
);

    always_comb begin
        cond_o = 1'b0;
        case (br_funct3_e'(funct3_i))
            BEQ:     cond_o = (rs1_i == rs2_i);
            BNE:     cond_o = (rs1_i != rs2_i);
            BLT:     cond_o = ($signed(rs1_i) <  $signed(rs2_i));
            BGE:     cond_o = ($signed(rs1_i) >= $signed(rs2_i));
            BLTU:    cond_o = (rs1_i <  rs2_i);
            BGEU:    cond_o = (rs1_i >= rs2_i);
            default: cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/br_resolve_unit.sv
// Carries fetch-time prediction metadata to EX, resolves the branch there and
// registers the commit record that trains the gshare predictor.
module br_resolve_unit
    import br_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH   = 6,
    parameter int unsigned HISTORY_WIDTH = BR_HISTORY_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               cnt_clr_i,
    br_resolve_unit_if.slave   bus,
    output logic [31:0]        br_count_o,
    output logic [31:0]        mispred_count_o
);

    localparam int unsigned TAG_W = 32 - INDEX_WIDTH - 2;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    br_meta_t ifid_q, ifid_d;
    br_meta_t idex_q, idex_d;

    logic        ex_cond;
    logic        ex_taken;
    logic        ex_commit;
    logic [31:0] ex_target;

    logic                     exmem_btb_hit_q,     exmem_btb_hit_d;
    logic                     exmem_br_decision_q, exmem_br_decision_d;
    logic                     exmem_is_jmp_q,      exmem_is_jmp_d;
    logic                     exmem_prediction_q,  exmem_prediction_d;
    logic [HISTORY_WIDTH-1:0] exmem_ghr_q,         exmem_ghr_d;
    logic [INDEX_WIDTH-1:0]   exmem_btb_index_q,   exmem_btb_index_d;
    logic [TAG_W-1:0]         exmem_btb_tag_q,     exmem_btb_tag_d;
    logic [31:0]              exmem_target_q,      exmem_target_d;
    logic [HISTORY_WIDTH-1:0] exmem_pht_index_q,   exmem_pht_index_d;
    logic [31:0]              exmem_pcplus4_q,     exmem_pcplus4_d;

    logic [31:0] br_cnt_q,      br_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    // IF/ID and ID/EX: flush kills both, stall holds both.
    always_comb begin
        ifid_d = ifid_q;
        idex_d = idex_q;
        if (flush_i) begin
            ifid_d.valid = 1'b0;
            idex_d.valid = 1'b0;
        end else if (!stall_i) begin
            ifid_d.valid       = bus.IF_valid_i;
            ifid_d.pc          = bus.IF_pc_i;
            ifid_d.btb_hit     = bus.IF_btb_hit_i;
            ifid_d.prediction  = bus.IF_prediction_i;
            ifid_d.pred_target = bus.IF_btb_target_i;
            ifid_d.ghr         = bus.IF_ghr_data_i;
            idex_d             = ifid_q;
        end
    end

    always_ff @(posedge clk_i) begin
        ifid_q <= ifid_d;
        idex_q <= idex_d;
        if (!rst_ni) begin
            ifid_q.valid <= 1'b0;
            idex_q.valid <= 1'b0;
        end
    end

    // EX: resolve direction and target of the instruction held in ID/EX.
    br_cond_unit u_cond (
        .funct3_i (bus.EX_funct3_i),
        .rs1_i    (bus.EX_rs1_i),
        .rs2_i    (bus.EX_rs2_i),
        .cond_o   (ex_cond)
    );

    assign ex_taken  = bus.EX_is_jal_i | bus.EX_is_jalr_i | (bus.EX_is_branch_i & ex_cond);
    assign ex_target = bus.EX_is_jalr_i ? ((bus.EX_rs1_i + bus.EX_imm_i) & ~32'd1)
                                        : (idex_q.pc + bus.EX_imm_i);
    // A stalled or flushed EX slot enters EX/MEM as a bubble so it commits once.
    assign ex_commit = idex_q.valid & ~flush_i & ~stall_i;

    always_comb begin
        exmem_btb_hit_d     = ex_commit & idex_q.btb_hit;
        exmem_br_decision_d = ex_commit & ex_taken;
        exmem_is_jmp_d      = ex_commit & (bus.EX_is_branch_i | bus.EX_is_jal_i);
        // A hit with the wrong target reports not-taken so the predictor redirects.
        exmem_prediction_d  = ex_commit & idex_q.prediction & (idex_q.pred_target == ex_target);
        exmem_ghr_d         = idex_q.ghr;
        exmem_btb_index_d   = idex_q.pc[INDEX_WIDTH+1:2];
        exmem_btb_tag_d     = idex_q.pc[31:INDEX_WIDTH+2];
        exmem_target_d      = ex_target;
        exmem_pht_index_d   = idex_q.pc[HISTORY_WIDTH+1:2];
        exmem_pcplus4_d     = idex_q.pc + 32'd4;
    end

    // EX/MEM: commit record, driven straight from these registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            exmem_btb_hit_q     <= 1'b0;
            exmem_br_decision_q <= 1'b0;
            exmem_is_jmp_q      <= 1'b0;
            exmem_prediction_q  <= 1'b0;
            exmem_ghr_q         <= '0;
            exmem_btb_index_q   <= '0;
            exmem_btb_tag_q     <= '0;
            exmem_target_q      <= '0;
            exmem_pht_index_q   <= '0;
            exmem_pcplus4_q     <= '0;
        end else begin
            exmem_btb_hit_q     <= exmem_btb_hit_d;
            exmem_br_decision_q <= exmem_br_decision_d;
            exmem_is_jmp_q      <= exmem_is_jmp_d;
            exmem_prediction_q  <= exmem_prediction_d;
            exmem_ghr_q         <= exmem_ghr_d;
            exmem_btb_index_q   <= exmem_btb_index_d;
            exmem_btb_tag_q     <= exmem_btb_tag_d;
            exmem_target_q      <= exmem_target_d;
            exmem_pht_index_q   <= exmem_pht_index_d;
            exmem_pcplus4_q     <= exmem_pcplus4_d;
        end
    end

    assign bus.EXMEM_btb_hit_o       = exmem_btb_hit_q;
    assign bus.EXMEM_br_decision_o   = exmem_br_decision_q;
    assign bus.EXMEM_is_jmp_o        = exmem_is_jmp_q;
    assign bus.EXMEM_prediction_o    = exmem_prediction_q;
    assign bus.EXMEM_ghr_data_o      = exmem_ghr_q;
    assign bus.EXMEM_btb_wr_index_o  = exmem_btb_index_q;
    assign bus.EXMEM_btb_wr_tag_o    = exmem_btb_tag_q;
    assign bus.EXMEM_btb_wr_target_o = exmem_target_q;
    assign bus.EXMEM_pht_wr_index_o  = exmem_pht_index_q;
    assign bus.EXMEM_pcplus4_o       = exmem_pcplus4_q;

    // Counters sample the registered record; is_jmp already implies a valid slot.
    always_comb begin
        br_cnt_d      = br_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (cnt_clr_i) begin
            br_cnt_d      = '0;
            mispred_cnt_d = '0;
        end else if (exmem_is_jmp_q) begin
            br_cnt_d = sat_inc(br_cnt_q);
            if (exmem_prediction_q != exmem_br_decision_q) begin
                mispred_cnt_d = sat_inc(mispred_cnt_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign br_count_o      = br_cnt_q;
    assign mispred_count_o = mispred_cnt_q;

endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed bench for br_resolve_unit: commit records are predicted at issue,
// queued, and matched against the EX/MEM outputs together with their cycle.
module tb_br_resolve_unit;
    import br_pkg::*;

    localparam int unsigned IW = 6;
    localparam int unsigned HW = BR_HISTORY_WIDTH;
    localparam int unsigned TW = 32 - IW - 2;

    typedef struct packed {
        logic [31:0]   pc;
        logic          hit;
        logic          pred;
        logic [31:0]   ptgt;
        logic [HW-1:0] ghr;
        logic          br;
        logic          jal;
        logic          jalr;
        logic [2:0]    f3;
        logic [31:0]   rs1;
        logic [31:0]   rs2;
        logic [31:0]   imm;
    } instr_t;

    typedef struct packed {
        logic          btb_hit;
        logic          dec;
        logic          is_jmp;
        logic          pred;
        logic [HW-1:0] ghr;
        logic [IW-1:0] idx;
        logic [TW-1:0] tag;
        logic [31:0]   tgt;
        logic [HW-1:0] pht;
        logic [31:0]   pc4;
    } rec_t;

    typedef struct {
        rec_t rec;
        int   edge_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        cnt_clr;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] exp_br = '0;
    logic [31:0] exp_mis = '0;

    always #5 clk = ~clk;

    br_resolve_unit_if #(.INDEX_WIDTH(IW), .HISTORY_WIDTH(HW)) bus ();

    br_resolve_unit #(.INDEX_WIDTH(IW), .HISTORY_WIDTH(HW)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .stall_i         (stall),
        .flush_i         (flush),
        .cnt_clr_i       (cnt_clr),
        .bus             (bus),
        .br_count_o      (br_count),
        .mispred_count_o (mispred_count)
    );

    function automatic instr_t mk(input logic [31:0] pc, input logic hit, input logic pred,
                                  input logic [31:0] ptgt, input logic [HW-1:0] ghr,
                                  input logic br, input logic jal, input logic jalr,
                                  input logic [2:0] f3, input logic [31:0] rs1,
                                  input logic [31:0] rs2, input logic [31:0] imm);
        instr_t i;
        i.pc = pc; i.hit = hit; i.pred = pred; i.ptgt = ptgt; i.ghr = ghr;
        i.br = br; i.jal = jal; i.jalr = jalr; i.f3 = f3;
        i.rs1 = rs1; i.rs2 = rs2; i.imm = imm;
        return i;
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic rec_t model(input instr_t i);
        rec_t        r;
        logic        c;
        logic [31:0] t;
        case (i.f3)
            3'd0:    c = (i.rs1 == i.rs2);
            3'd1:    c = (i.rs1 != i.rs2);
            3'd4:    c = ($signed(i.rs1) < $signed(i.rs2));
            3'd5:    c = ($signed(i.rs1) >= $signed(i.rs2));
            3'd6:    c = (i.rs1 < i.rs2);
            3'd7:    c = (i.rs1 >= i.rs2);
            default: c = 1'b0;
        endcase
        t = i.jalr ? ((i.rs1 + i.imm) & 32'hFFFF_FFFE) : (i.pc + i.imm);
        r.btb_hit = i.hit;
        r.dec     = i.jal | i.jalr | (i.br & c);
        r.is_jmp  = i.br | i.jal;
        r.pred    = i.pred & (i.ptgt == t);
        r.ghr     = i.ghr;
        r.idx     = i.pc[IW+1:2];
        r.tag     = i.pc[31:IW+2];
        r.tgt     = t;
        r.pht     = i.pc[HW+1:2];
        r.pc4     = i.pc + 32'd4;
        return r;
    endfunction

    task automatic issue(input instr_t i, input int edge_n);
        exp_t e;
        e.rec    = model(i);
        e.edge_n = edge_n;
        sb.push_back(e);
        if (e.rec.is_jmp) begin
            exp_br = sat(exp_br);
            if (e.rec.pred != e.rec.dec) exp_mis = sat(exp_mis);
        end
    endtask

    task automatic drive_if(input logic v, input instr_t i);
        bus.IF_valid_i      = v;
        bus.IF_pc_i         = i.pc;
        bus.IF_btb_hit_i    = i.hit;
        bus.IF_prediction_i = i.pred;
        bus.IF_btb_target_i = i.ptgt;
        bus.IF_ghr_data_i   = i.ghr;
    endtask

    task automatic drive_ex(input logic v, input instr_t i);
        bus.EX_is_branch_i = v & i.br;
        bus.EX_is_jal_i    = v & i.jal;
        bus.EX_is_jalr_i   = v & i.jalr;
        bus.EX_funct3_i    = i.f3;
        bus.EX_rs1_i       = i.rs1;
        bus.EX_rs2_i       = i.rs2;
        bus.EX_imm_i       = i.imm;
    endtask

    function automatic rec_t observe();
        rec_t o;
        o.btb_hit = bus.EXMEM_btb_hit_o;
        o.dec     = bus.EXMEM_br_decision_o;
        o.is_jmp  = bus.EXMEM_is_jmp_o;
        o.pred    = bus.EXMEM_prediction_o;
        o.ghr     = bus.EXMEM_ghr_data_o;
        o.idx     = bus.EXMEM_btb_wr_index_o;
        o.tag     = bus.EXMEM_btb_wr_tag_o;
        o.tgt     = bus.EXMEM_btb_wr_target_o;
        o.pht     = bus.EXMEM_pht_wr_index_o;
        o.pc4     = bus.EXMEM_pcplus4_o;
        return o;
    endfunction

    task automatic monitor();
        rec_t obs;
        exp_t e;
        obs = observe();
        if (obs.btb_hit | obs.dec | obs.is_jmp | obs.pred) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_commit cyc=%0d got=%h expected no record", cyc, obs);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                assert (obs === e.rec) else begin
                    errors++;
                    $error("FAIL record cyc=%0d got=%h expected=%h", cyc, obs, e.rec);
                end
                checks++;
                assert (cyc === e.edge_n) else begin
                    errors++;
                    $error("FAIL latency got cycle %0d expected cycle %0d", cyc, e.edge_n);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic chk_cnt(input string tag);
        checks++;
        assert (br_count === exp_br) else begin
            errors++;
            $error("FAIL %s br_count got %h expected %h", tag, br_count, exp_br);
        end
        checks++;
        assert (mispred_count === exp_mis) else begin
            errors++;
            $error("FAIL %s mispred_count got %h expected %h", tag, mispred_count, exp_mis);
        end
    endtask

    task automatic chk_zero(input string tag);
        rec_t obs;
        obs = observe();
        checks++;
        assert (obs === '0) else begin
            errors++;
            $error("FAIL %s outputs got %h expected 0", tag, obs);
        end
    endtask

    task automatic run_one(input instr_t i);
        drive_if(1'b1, i);
        drive_ex(1'b0, i);
        issue(i, cyc + 3);
        step();
        drive_if(1'b0, i);
        step();
        drive_ex(1'b1, i);
        step();
        drive_ex(1'b0, i);
    endtask

    instr_t nop_i = '0;
    instr_t tbl[8];
    instr_t ia, ib, ic, id;

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        drive_if(1'b0, nop_i);
        drive_ex(1'b0, nop_i);
        step();
        step();
        chk_zero("reset");
        chk_cnt("reset");
        rst_n = 1'b1;
        step();

        // BEQ taken, correctly predicted
        run_one(mk(32'h100, 1, 1, 32'h140, 8'hA5, 1, 0, 0, 3'd0, 32'd5, 32'd5, 32'h40));
        step();
        chk_cnt("beq");

        // BLTU taken, predicted with the wrong target
        run_one(mk(32'h140, 1, 1, 32'h200, 8'h3C, 1, 0, 0, 3'd6, 32'd1, 32'hFFFF_FFFF, 32'h40));
        step();
        chk_cnt("bltu_wrong_tgt");

        // JALR: target low bit cleared, not counted
        run_one(mk(32'h200, 0, 0, 32'h0, 8'h11, 0, 0, 1, 3'd0, 32'h1003, 32'h0, 32'h0));
        step();
        chk_cnt("jalr");

        tbl[0] = mk(32'h600, 0, 0, 32'h0, 8'h01, 1, 0, 0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h10);
        tbl[1] = mk(32'h604, 1, 1, 32'h614, 8'h02, 1, 0, 0, 3'd5, 32'hFFFF_FFFF, 32'd1, 32'h10);
        tbl[2] = mk(32'h608, 0, 0, 32'h0, 8'h04, 1, 0, 0, 3'd1, 32'd7, 32'd7, 32'h10);
        tbl[3] = mk(32'hDEAD_BEE0, 1, 1, 32'hDEAD_BED0, 8'h08, 1, 0, 0, 3'd7,
                    32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0);
        tbl[4] = mk(32'h610, 1, 1, 32'h620, 8'h10, 1, 0, 0, 3'd2, 32'd3, 32'd3, 32'h10);
        tbl[5] = mk(32'h614, 1, 1, 32'h60C, 8'h20, 0, 1, 0, 3'd0, 32'd0, 32'd0, 32'hFFFF_FFF8);
        tbl[6] = mk(32'h618, 1, 1, 32'h2004, 8'h40, 0, 0, 1, 3'd0, 32'h2000, 32'd0, 32'h5);
        tbl[7] = mk(32'h61C, 0, 0, 32'h0, 8'h80, 1, 0, 0, 3'd3, 32'd9, 32'd1, 32'h8);
        for (int k = 0; k < 8; k++) run_one(tbl[k]);
        step();
        chk_cnt("table");

        // Flush: only the flushing branch commits
        ia = mk(32'h400, 0, 0, 32'h0, 8'h55, 1, 0, 0, 3'd1, 32'd1, 32'd2, 32'h20);
        ib = mk(32'h404, 1, 1, 32'h40C, 8'h56, 1, 0, 0, 3'd0, 32'd4, 32'd4, 32'h8);
        ic = mk(32'h408, 1, 1, 32'h500, 8'h57, 0, 1, 0, 3'd0, 32'd0, 32'd0, 32'hF8);
        id = mk(32'h40C, 1, 0, 32'h0, 8'h58, 1, 0, 0, 3'd5, 32'd2, 32'd1, 32'h4);
        drive_if(1'b1, ia);
        issue(ia, cyc + 3);
        step();
        drive_if(1'b1, ib);
        step();
        drive_if(1'b1, ic);
        drive_ex(1'b1, ia);
        step();
        flush = 1'b1;
        drive_if(1'b1, id);
        drive_ex(1'b1, ib);
        step();
        flush = 1'b0;
        drive_if(1'b0, nop_i);
        drive_ex(1'b1, ic);
        step();
        drive_ex(1'b1, id);
        step();
        drive_ex(1'b0, nop_i);
        step();
        step();
        chk_cnt("flush");

        // Stall with the branch in EX for three cycles
        ia = mk(32'h500, 1, 1, 32'h510, 8'h66, 1, 0, 0, 3'd5, 32'd5, 32'd3, 32'h10);
        drive_if(1'b1, ia);
        issue(ia, cyc + 6);
        step();
        drive_if(1'b0, nop_i);
        step();
        drive_ex(1'b1, ia);
        stall = 1'b1;
        step();
        step();
        step();
        stall = 1'b0;
        step();
        drive_ex(1'b0, nop_i);
        step();
        chk_cnt("stall");

        // Saturation: preload both counters, then commit a mispredicted branch
        force dut.br_cnt_q = 32'hFFFF_FFFF;
        force dut.mispred_cnt_q = 32'hFFFF_FFFF;
        step();
        release dut.br_cnt_q;
        release dut.mispred_cnt_q;
        exp_br  = 32'hFFFF_FFFF;
        exp_mis = 32'hFFFF_FFFF;
        run_one(mk(32'h700, 0, 0, 32'h0, 8'h77, 1, 0, 0, 3'd0, 32'd1, 32'd1, 32'h40));
        step();
        chk_cnt("saturate");

        // Clear in the same cycle as an increment
        run_one(mk(32'h800, 0, 0, 32'h0, 8'h88, 1, 0, 0, 3'd0, 32'd1, 32'd1, 32'h40));
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        exp_br  = '0;
        exp_mis = '0;
        chk_cnt("clear");

        // Reset mid-stream discards every in-flight record
        ia = mk(32'h900, 1, 1, 32'h940, 8'h99, 1, 0, 0, 3'd0, 32'd2, 32'd2, 32'h40);
        ib = mk(32'h904, 1, 1, 32'h944, 8'h9A, 1, 0, 0, 3'd0, 32'd2, 32'd2, 32'h40);
        ic = mk(32'h908, 1, 1, 32'h948, 8'h9B, 1, 0, 0, 3'd0, 32'd2, 32'd2, 32'h40);
        drive_if(1'b1, ia);
        issue(ia, cyc + 3);
        step();
        drive_if(1'b1, ib);
        step();
        drive_if(1'b1, ic);
        drive_ex(1'b1, ia);
        step();
        rst_n = 1'b0;
        drive_if(1'b0, nop_i);
        drive_ex(1'b1, ib);
        step();
        exp_br  = '0;
        exp_mis = '0;
        chk_zero("mid_reset");
        chk_cnt("mid_reset");
        rst_n = 1'b1;
        drive_ex(1'b1, ic);
        step();
        step();
        drive_ex(1'b0, nop_i);
        step();
        chk_cnt("after_reset");

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain pending records got %0d expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
